alu_ctrl: RTL and testbench
===========================

// Module: alu_ctrl
// PURPOSE
//  Command sequencer for the 16-bit Hack-style ALU (x, y, zx, nx, zy, ny, f, no -> out, zr, ng).
//  Accepts {op, a, b} commands over a valid/ready handshake and decodes op into the six ALU control bits.
//  Drives an external ALU instance and returns result and flags over a valid/ready response channel.
//  Optional multi-cycle MUL: shift-and-add, with every add performed through the ALU.
// PARAMETERS
//  WIDTH     16   datapath width; must equal ALU width
//  MUL_STEPS 16   shift-add iterations for MUL; must equal WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      controller can accept a command
//  cmd_op     in   4      opcode (table below)
//  cmd_a      in   WIDTH  operand x
//  cmd_b      in   WIDTH  operand y
//  rsp_valid  out  1      response available
//  rsp_ready  in   1      consumer takes response
//  rsp_data   out  WIDTH  result
//  rsp_zr     out  1      result == 0
//  rsp_ng     out  1      result MSB
//  rsp_err    out  1      illegal opcode
//  alu_x      out  WIDTH  ALU x operand
//  alu_y      out  WIDTH  ALU y operand
//  alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
//  alu_out    in   WIDTH  ALU result
//  alu_zr     in   1      ALU zero flag
//  alu_ng     in   1      ALU negative flag
// BEHAVIOUR
//  Opcodes (zx nx zy ny f no):
//   0 ZERO 101010, 1 ONE 111111, 2 NEG1 111010, 3 X 001100, 4 Y 110000, 5 NOTX 001101,
//   6 NOTY 110001, 7 NEGX 001111, 8 NEGY 110011, 9 XP1 011111, 10 ADD 000010,
//   11 SUB(x-y) 010011, 12 RSUB(y-x) 000111, 13 AND 000000, 14 OR 010101, 15 MUL (multi-cycle).
//  FSM states:
//   - IDLE -> EXEC on handshake (single-cycle op).
//   - IDLE -> MUL on handshake (op 15).
//   - EXEC -> RESP.
//   - MUL -> RESP after MUL_STEPS steps.
//   - RESP -> IDLE on rsp_valid && rsp_ready.
//  Handshake:
//   - cmd_ready = (state==IDLE) && !reset.
//   - Command accepted in cycle N when cmd_valid && cmd_ready; op/a/b latched at that edge.
//  Single-cycle op:
//   - EXEC in cycle N+1: alu_x/alu_y = latched a/b; control bits from the table.
//   - alu_out/zr/ng captured into rsp_* at end of N+1.
//   - rsp_valid = 1 from N+2.
//  MUL:
//   - Latch acc=0, mc=a, mp=b.
//   - Each MUL cycle: alu_x=acc, alu_y=mc, ADD control bits.
//   - If mp[0]=1, acc<=alu_out. Always mc<=mc<<1, mp<=mp>>1.
//   - After exactly MUL_STEPS cycles (N+1..N+16): rsp_data = acc, the low WIDTH bits of a*b (wraps mod 2^16).
//   - rsp_zr=(acc==0), rsp_ng=acc[15]; rsp_valid from N+17. Fixed latency, no early exit.
//  Response:
//   - rsp_data/zr/ng/err held stable while rsp_valid && !rsp_ready.
//   - rsp_valid drops the cycle after the handshake.
//   - Next command can be accepted no earlier than the cycle after the response handshake; minimum 3 cycles per op.
//  Idle ALU drive: outside EXEC/MUL, alu_x = alu_y = 0 and controls = ZERO pattern 101010.
//  Arithmetic wraps mod 2^WIDTH; overflow is not flagged.
//  Reset (any state, including mid-MUL): state=IDLE, all latched values discarded.
//   - rsp_valid=0, rsp_data=0, rsp_zr=0, rsp_ng=0, rsp_err=0.
//   - cmd_ready=0 during reset, 1 in the first cycle after.
//  cmd_valid during a non-IDLE state is ignored; the command is not consumed.
// CONFIGURATION
//  ALU_CTRL_MUL_EN defined:
//   - op 15 runs MUL as above.
//  ALU_CTRL_MUL_EN undefined:
//   - MUL datapath and state absent.
//   - op 15 goes IDLE -> EXEC with ALU driven idle, then RESP.
//   - Response at N+2: rsp_err=1, rsp_data=0, rsp_zr=1, rsp_ng=0.
//  rsp_err is 0 for ops 0-14 in both builds.
// TESTING
//  1 ADD a=0x0005 b=0x0003 -> rsp_valid at N+2, data=0x0008 zr=0 ng=0 err=0.
//  2 SUB a=0x0003 b=0x0005 -> data=0xFFFE ng=1; RSUB same operands -> data=0x0002; AND/OR a=0x00F0 b=0x0F0F -> 0x0000 zr=1 / 0x0FFF.
//  3 MUL a=0x0007 b=0x0006, rsp_ready=1 (MUL_EN) -> rsp_valid exactly at N+17, data=0x002A;
//    a=0x0100 b=0x0100 -> data=0x0000 zr=1. Without MUL_EN: op 15 -> err=1 at N+2.
//  4 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> data/flags stable, cmd_ready=0;
//    cmd_valid held high is accepted only the cycle after rsp handshake.
//  5 Reset at step 8 of a MUL -> next cycle rsp_valid=0, cmd_ready=1;
//    a following ADD 1+1 returns 0x0002 with no stale MUL result.
//  6 Sweep all 15 non-MUL ops with a=0x1234 b=0x00FF -> alu_* control bits match the table in EXEC;
//    rsp_data matches a reference model.

Source files
------------

// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer for an external 16-bit Hack-style ALU.
// Decodes {op, a, b} commands into ALU control bits and returns result and flags.
// Each command uses a valid/ready handshake, and so does each response.
// Build option ALU_CTRL_MUL_EN enables op 15 as a shift-and-add multiply.
// Every partial-product add goes through the external ALU.
// Without that macro, op 15 is answered with rsp_err=1.
module alu_ctrl #(
   parameter int WIDTH     = 16,
   parameter int MUL_STEPS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zr,
   output logic             rsp_ng,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic             alu_zx,
   output logic             alu_nx,
   output logic             alu_zy,
   output logic             alu_ny,
   output logic             alu_f,
   output logic             alu_no,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd3;
`ifdef ALU_CTRL_MUL_EN
   localparam logic [1:0] ST_MUL  = 2'd2;
   localparam int         STEP_W  = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_STEPS - 1);
`endif

   localparam logic [3:0] OP_MUL    = 4'd15;
   localparam logic [5:0] CTRL_ZERO = 6'b101010;
   localparam logic [5:0] CTRL_ADD  = 6'b000010;

   // The multiply loop relies on one shift-add per result bit.
   generate
      if (MUL_STEPS != WIDTH) begin : g_bad_cfg
         $error("alu_ctrl: MUL_STEPS must equal WIDTH");
      end
   endgenerate

   // Control word {zx,nx,zy,ny,f,no} for each single-cycle opcode.
   // Op 15 falls through to the idle ZERO pattern.
   function automatic logic [5:0] f_decode(input logic [3:0] op);
      case (op)
         4'd0:    f_decode = 6'b101010;
         4'd1:    f_decode = 6'b111111;
         4'd2:    f_decode = 6'b111010;
         4'd3:    f_decode = 6'b001100;
         4'd4:    f_decode = 6'b110000;
         4'd5:    f_decode = 6'b001101;
         4'd6:    f_decode = 6'b110001;
         4'd7:    f_decode = 6'b001111;
         4'd8:    f_decode = 6'b110011;
         4'd9:    f_decode = 6'b011111;
         4'd10:   f_decode = 6'b000010;
         4'd11:   f_decode = 6'b010011;
         4'd12:   f_decode = 6'b000111;
         4'd13:   f_decode = 6'b000000;
         4'd14:   f_decode = 6'b010101;
         default: f_decode = CTRL_ZERO;
      endcase
   endfunction

   logic [1:0]       r_state;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_zr;
   logic             r_rsp_ng;
   logic             r_rsp_err;
   logic [5:0]       w_ctrl;
   logic             w_cmd_fire;
`ifdef ALU_CTRL_MUL_EN
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mc;
   logic [WIDTH-1:0] r_mp;
   logic [STEP_W-1:0] r_step;
   logic [WIDTH-1:0] w_acc_next;

   // The ALU sum is kept only when the current multiplier bit is set.
   assign w_acc_next = r_mp[0] ? alu_out : r_acc;
`endif

   assign cmd_ready  = (r_state == ST_IDLE) && !reset;
   assign w_cmd_fire = cmd_valid && cmd_ready;
   assign rsp_valid  = (r_state == ST_RESP);
   assign rsp_data   = r_rsp_data;
   assign rsp_zr     = r_rsp_zr;
   assign rsp_ng     = r_rsp_ng;
   assign rsp_err    = r_rsp_err;
   assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = w_ctrl;

   // Drive the ALU: latched operands in EXEC, acc + mc in MUL, otherwise the ZERO pattern.
   always_comb begin
      w_ctrl = CTRL_ZERO;
      alu_x  = '0;
      alu_y  = '0;
      if (r_state == ST_EXEC && r_op != OP_MUL) begin
         w_ctrl = f_decode(r_op);
         alu_x  = r_a;
         alu_y  = r_b;
      end
`ifdef ALU_CTRL_MUL_EN
      if (r_state == ST_MUL) begin
         w_ctrl = CTRL_ADD;
         alu_x  = r_acc;
         alu_y  = r_mc;
      end
`endif
   end

   // Sequencer FSM: accept a command, run it, then hold the response until it is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_rsp_data <= '0;
         r_rsp_zr   <= 1'b0;
         r_rsp_ng   <= 1'b0;
         r_rsp_err  <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
         r_acc      <= '0;
         r_mc       <= '0;
         r_mp       <= '0;
         r_step     <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  r_op    <= cmd_op;
                  r_a     <= cmd_a;
                  r_b     <= cmd_b;
                  r_state <= ST_EXEC;
`ifdef ALU_CTRL_MUL_EN
                  if (cmd_op == OP_MUL) begin
                     r_acc   <= '0;
                     r_mc    <= cmd_a;
                     r_mp    <= cmd_b;
                     r_step  <= '0;
                     r_state <= ST_MUL;
                  end
`endif
               end
            end
            ST_EXEC: begin
               // Op 15 only reaches EXEC when multiply is not built in.
               if (r_op == OP_MUL) begin
                  r_rsp_data <= '0;
                  r_rsp_zr   <= 1'b1;
                  r_rsp_ng   <= 1'b0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_rsp_data <= alu_out;
                  r_rsp_zr   <= alu_zr;
                  r_rsp_ng   <= alu_ng;
                  r_rsp_err  <= 1'b0;
               end
               r_state <= ST_RESP;
            end
`ifdef ALU_CTRL_MUL_EN
            ST_MUL: begin
               // Fixed-latency multiply: no early exit, even if the multiplier has no bits left.
               r_acc  <= w_acc_next;
               r_mc   <= r_mc << 1;
               r_mp   <= r_mp >> 1;
               r_step <= r_step + STEP_W'(1);
               if (r_step == STEP_LAST) begin
                  r_rsp_data <= w_acc_next;
                  r_rsp_zr   <= (w_acc_next == '0);
                  r_rsp_ng   <= w_acc_next[WIDTH-1];
                  r_rsp_err  <= 1'b0;
                  r_state    <= ST_RESP;
               end
            end
`endif
            ST_RESP: begin
               if (rsp_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench for alu_ctrl with a behavioural Hack ALU attached.
// The multiply cases are selected by ALU_CTRL_MUL_EN, matching the DUT build.
module tb_alu_ctrl;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data;
   logic          rsp_zr;
   logic          rsp_ng;
   logic          rsp_err;
   logic [W-1:0]  alu_x;
   logic [W-1:0]  alu_y;
   logic          alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
   logic [W-1:0]  alu_out;
   logic          alu_zr;
   logic          alu_ng;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_ctrl #(.WIDTH(W), .MUL_STEPS(W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_err(rsp_err),
      .alu_x(alu_x), .alu_y(alu_y),
      .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
      .alu_f(alu_f), .alu_no(alu_no),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
   );

   // Behavioural Hack ALU
   logic [W-1:0] m_x1, m_x2, m_y1, m_y2, m_o;
   always_comb begin
      m_x1    = alu_zx ? '0 : alu_x;
      m_x2    = alu_nx ? ~m_x1 : m_x1;
      m_y1    = alu_zy ? '0 : alu_y;
      m_y2    = alu_ny ? ~m_y1 : m_y1;
      m_o     = alu_f ? (m_x2 + m_y2) : (m_x2 & m_y2);
      alu_out = alu_no ? ~m_o : m_o;
      alu_zr  = (alu_out == '0);
      alu_ng  = alu_out[W-1];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] exp_ctrl(input int op);
      case (op)
         0: return 6'b101010;  1: return 6'b111111;  2: return 6'b111010;
         3: return 6'b001100;  4: return 6'b110000;  5: return 6'b001101;
         6: return 6'b110001;  7: return 6'b001111;  8: return 6'b110011;
         9: return 6'b011111; 10: return 6'b000010; 11: return 6'b010011;
        12: return 6'b000111; 13: return 6'b000000; 14: return 6'b010101;
         default: return 6'b101010;
      endcase
   endfunction

   // Reference semantics of each opcode, written arithmetically.
   function automatic logic [W-1:0] exp_data(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         0: return 16'h0000;  1: return 16'h0001;  2: return 16'hFFFF;
         3: return a;         4: return b;         5: return ~a;
         6: return ~b;        7: return 16'h0000 - a;  8: return 16'h0000 - b;
         9: return a + 16'h0001; 10: return a + b; 11: return a - b;
        12: return b - a;    13: return a & b;    14: return a | b;
         default: return 16'h0000;
      endcase
   endfunction

   // One complete transaction: offer, wait for response, take it, confirm the release.
   task automatic do_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic zr, output logic ng, output logic err,
                         output int lat, output logic [5:0] ctrl);
      int guard;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      guard = 0;
      while (!cmd_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0; ctrl = 6'b0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
      end while (!rsp_valid && lat < 40);
      if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      d = rsp_data; zr = rsp_zr; ng = rsp_ng; err = rsp_err;
      $display("op=%0d a=%h b=%h -> data=%h zr=%0d ng=%0d err=%0d lat=%0d", op, a, b, d, zr, ng, err, lat);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic expect_rsp(input string tag, input logic [W-1:0] d, input logic zr, input logic ng,
                             input logic err, input int lat, input logic [W-1:0] e_d, input logic e_zr,
                             input logic e_ng, input logic e_err, input int e_lat);
      check({tag, "_data"}, {16'd0, d}, {16'd0, e_d});
      check({tag, "_zr"}, {31'd0, zr}, {31'd0, e_zr});
      check({tag, "_ng"}, {31'd0, ng}, {31'd0, e_ng});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
      check({tag, "_lat"}, lat, e_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] d;
      logic zr, ng, err;
      int lat;
      logic [5:0] ctrl;
      logic [W-1:0] ea, eb, ed;

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      check("rst_flags", {29'd0, rsp_zr, rsp_ng, rsp_err}, 32'd0);
      check("rst_alu_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);
      check("rst_alu_xy", {alu_x, alu_y}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // Basic arithmetic and logic
      do_cmd(4'd10, 16'h0005, 16'h0003, d, zr, ng, err, lat, ctrl);
      expect_rsp("add", d, zr, ng, err, lat, 16'h0008, 1'b0, 1'b0, 1'b0, 2);
      do_cmd(4'd11, 16'h0003, 16'h0005, d, zr, ng, err, lat, ctrl);
      expect_rsp("sub", d, zr, ng, err, lat, 16'hFFFE, 1'b0, 1'b1, 1'b0, 2);
      do_cmd(4'd12, 16'h0003, 16'h0005, d, zr, ng, err, lat, ctrl);
      expect_rsp("rsub", d, zr, ng, err, lat, 16'h0002, 1'b0, 1'b0, 1'b0, 2);
      do_cmd(4'd13, 16'h00F0, 16'h0F0F, d, zr, ng, err, lat, ctrl);
      expect_rsp("and", d, zr, ng, err, lat, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
      do_cmd(4'd14, 16'h00F0, 16'h0F0F, d, zr, ng, err, lat, ctrl);
      expect_rsp("or", d, zr, ng, err, lat, 16'h0FFF, 1'b0, 1'b0, 1'b0, 2);

      // Op 15
`ifdef ALU_CTRL_MUL_EN
      do_cmd(4'd15, 16'h0007, 16'h0006, d, zr, ng, err, lat, ctrl);
      expect_rsp("mul_7x6", d, zr, ng, err, lat, 16'h002A, 1'b0, 1'b0, 1'b0, 17);
      check("mul_ctrl", {26'd0, ctrl}, 32'h02);
      do_cmd(4'd15, 16'h0100, 16'h0100, d, zr, ng, err, lat, ctrl);
      expect_rsp("mul_wrap", d, zr, ng, err, lat, 16'h0000, 1'b1, 1'b0, 1'b0, 17);
      do_cmd(4'd15, 16'hFFFF, 16'h0003, d, zr, ng, err, lat, ctrl);
      expect_rsp("mul_neg", d, zr, ng, err, lat, 16'hFFFD, 1'b0, 1'b1, 1'b0, 17);
`else
      do_cmd(4'd15, 16'h0007, 16'h0006, d, zr, ng, err, lat, ctrl);
      expect_rsp("mul_off", d, zr, ng, err, lat, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
      check("mul_off_ctrl", {26'd0, ctrl}, 32'h2A);
`endif

      // Backpressure: response held, cmd_valid held high is not consumed until after handshake
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd10; cmd_a = 16'h0005; cmd_b = 16'h0003;
      @(posedge clk); #1;
      cmd_a = 16'h0001; cmd_b = 16'h0002;
      @(negedge clk);
      check("bp_exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_hold_data", {16'd0, rsp_data}, 32'h0008);
         check("bp_hold_flags", {29'd0, rsp_zr, rsp_ng, rsp_err}, 32'd0);
         check("bp_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         if (i < 4) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("bp_accept_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_second_exec", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_second_data", {16'd0, rsp_data}, 32'h0003);
      $display("op=10 a=0001 b=0002 -> data=%h (queued behind backpressure)", rsp_data);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset while a command is in flight
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 16'h0007; cmd_b = 16'h0006;
`ifdef ALU_CTRL_MUL_EN
      cmd_op = 4'd15;
`else
      cmd_op = 4'd11;
`endif
      @(posedge clk); #1;
      cmd_valid = 1'b0;
`ifdef ALU_CTRL_MUL_EN
      repeat (8) @(negedge clk);
      check("midmul_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h02);
`else
      @(negedge clk);
      check("midexec_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h13);
`endif
      check("midop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("inrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_rsp_data", {16'd0, rsp_data}, 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_stale", {31'd0, rsp_valid}, 32'd0);
      do_cmd(4'd10, 16'h0001, 16'h0001, d, zr, ng, err, lat, ctrl);
      expect_rsp("post_abort_add", d, zr, ng, err, lat, 16'h0002, 1'b0, 1'b0, 1'b0, 2);

      // Sweep of every single-cycle opcode
      ea = 16'h1234; eb = 16'h00FF;
      for (int op = 0; op < 15; op++) begin
         do_cmd(op[3:0], ea, eb, d, zr, ng, err, lat, ctrl);
         ed = exp_data(op, ea, eb);
         check($sformatf("sweep%0d_ctrl", op), {26'd0, ctrl}, {26'd0, exp_ctrl(op)});
         expect_rsp($sformatf("sweep%0d", op), d, zr, ng, err, lat, ed, (ed == 16'h0000), ed[15], 1'b0, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
